// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIV_DZ_EN to add the dz output and a one-edge divide-by-zero shortcut.
module seq_div #(
  parameter int DW = 6,
  parameter int VW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r
`ifdef SEQ_DIV_DZ_EN
  ,
  output logic          dz
`endif
);

  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
`ifdef SEQ_DIV_DZ_EN
  logic          dz_q, dz_d;
`endif

  logic [VW:0]   rem_shift;
  logic [VW:0]   rem_next;
  logic          qbit;

  // With a correct invariant R < b, the shifted remainder stays below 2b and fits VW+1 bits.
  always_comb begin
    rem_shift = {rem_q[VW-1:0], dvd_q[DW-1]};
    qbit      = (rem_shift >= {1'b0, dvs_q});
    rem_next  = qbit ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef SEQ_DIV_DZ_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef SEQ_DIV_DZ_EN
          dz_d    = 1'b0;
          if (b == '0) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = a[VW-1:0];
            dz_d    = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_next;
        q_d   = {q_q[DW-2:0], qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = S_DONE;
          r_d     = rem_next[VW-1:0];
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef SEQ_DIV_DZ_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef SEQ_DIV_DZ_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign q    = q_q;
  assign r    = r_q;
`ifdef SEQ_DIV_DZ_EN
  assign dz   = dz_q;
`endif

endmodule
